// File: rtl/modbus_pkg.sv
// Shared constants, state encodings and CRC helper
// for the Modbus RTU transmit path.
package modbus_pkg;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam int FRAME_END_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT,
    ST_CRC_HI,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    SRC_DATA,
    SRC_CRC_LO,
    SRC_CRC_HI
  } src_t;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_rtu_tx_uart.sv
// UART character shifter: start, 8 data LSB first,
// optional parity, stop bits; done pulses in last clock.
module uart_tx_core #(
  parameter int CLK_DIV   = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CHAR_BITS = 9 + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int SW = CHAR_BITS - 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(CHAR_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHAR_BITS - 1);

  logic [CHAR_BITS-1:0] frame;
  logic [SW-1:0]        shreg;
  logic [BW-1:0]        bit_cnt;
  logic [IW-1:0]        idx;
  logic                 active;
  logic                 tx_q;

  always_comb begin
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = data;
    if (PARITY != 0) begin
      frame[9] = (^data) ^ (PARITY == 2);
    end
  end

  assign done = active && (bit_cnt == BIT_LAST) && (idx == IDX_LAST);
  assign tx   = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '1;
      bit_cnt <= '0;
      idx     <= '0;
      active  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (load) begin
      shreg   <= frame[CHAR_BITS-1:1];
      tx_q    <= frame[0];
      bit_cnt <= '0;
      idx     <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        if (idx == IDX_LAST) begin
          active <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          idx   <= idx + 1'b1;
          tx_q  <= shreg[0];
          shreg <= {1'b1, shreg[SW-1:1]};
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/modbus_rtu_tx.sv
// Modbus RTU frame transmitter: handshake, CRC append,
// RS-485 enable, inter-frame silence and underrun flag.
module modbus_rtu_tx
  import modbus_pkg::*;
#(
  parameter int CLK_DIV       = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int SILENCE_BITS  = 39,
  parameter int UNDERRUN_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] dataIn,
  input  logic       writeReq,
  output logic       writeAck,
  output logic       tx,
  output logic       txEnable,
  output logic       busy,
  output logic       underrun
);

  localparam int MAX_BITS =
    (SILENCE_BITS > UNDERRUN_BITS) ? SILENCE_BITS : UNDERRUN_BITS;
  localparam int CNT_MAX = MAX_BITS * CLK_DIV;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
  localparam logic [CW-1:0] GAP_LAST = CW'(SILENCE_BITS * CLK_DIV - 1);
  localparam logic [CW-1:0] UND_LAST = CW'(UNDERRUN_BITS * CLK_DIV - 1);

  state_t        state_q, state_n;
  src_t          src_q;
  logic [7:0]    byte_q;
  logic [15:0]   crc_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q;
  logic          under_q;
  logic          sample;
  logic          accept;
  logic          marker;
  logic          load;
  logic          done;

  assign marker = dataIn[FRAME_END_BIT];
  // ack cycle in IDLE must not re-sample the still-held request
  assign sample = ((state_q == ST_IDLE) && !ack_q) || (state_q == ST_WAIT);
  assign accept = sample && writeReq;
  assign load   = (state_q == ST_LOAD);

  assign writeAck = ack_q;
  assign underrun = under_q;
  assign busy     = (state_q != ST_IDLE);
  assign txEnable = (state_q != ST_IDLE) && (state_q != ST_GAP);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept && !marker) state_n = ST_LOAD;
      ST_LOAD:   state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (done) begin
          unique case (src_q)
            SRC_DATA:   state_n = ST_WAIT;
            SRC_CRC_LO: state_n = ST_CRC_HI;
            default:    state_n = ST_GAP;
          endcase
        end
      end
      ST_WAIT:   if (accept) state_n = ST_LOAD;
      ST_CRC_HI: state_n = ST_LOAD;
      ST_GAP:    if (cnt_q == GAP_LAST) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_DATA;
      byte_q  <= '0;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ack_q   <= accept;
      under_q <= (state_q == ST_WAIT) && (cnt_q == UND_LAST);
      if (state_n != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept && !marker) begin
        byte_q <= dataIn[7:0];
        crc_q  <= crc16_byte(crc_q, dataIn[7:0]);
        src_q  <= SRC_DATA;
      end else if (accept && (state_q == ST_WAIT)) begin
        byte_q <= crc_q[7:0];
        src_q  <= SRC_CRC_LO;
      end
      if (state_q == ST_CRC_HI) begin
        byte_q <= crc_q[15:8];
        src_q  <= SRC_CRC_HI;
      end
      if ((state_q == ST_GAP) && (state_n == ST_IDLE)) begin
        crc_q <= CRC_INIT;
      end
    end
  end

  uart_tx_core #(
    .CLK_DIV  (CLK_DIV),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .load(load),
    .data(byte_q),
    .tx  (tx),
    .done(done)
  );

endmodule
